base642a_rx: RTL
================

// Module: base642a_rx
// PURPOSE
//  Base64-to-ASCII decoder; the receive end of the a2base path. Consumes base64
//  character codes (A-Z a-z 0-9 + / =) through a valid/ready handshake, repacks
//  the 6-bit values MSB-first into 7-bit ASCII characters, and emits them through
//  a second valid/ready handshake. sym_last marks the final symbol of a stream.
//  Trailing bits that do not fill a whole character are discarded and reported.
// PARAMETERS
//  CNT_W   16   width of char_cnt (count of emitted characters)
// PORTS
//  clk          in   1      system clock, rising edge
//  rst_n        in   1      asynchronous active-low reset
//  sym_in       in   7      base64 character code (ASCII)
//  sym_valid    in   1      sym_in valid
//  sym_ready    out  1      decoder accepts sym_in this cycle
//  sym_last     in   1      qualifies sym_in: last symbol of stream
//  ascii        out  7      decoded ASCII character
//  ascii_valid  out  1      ascii valid
//  ascii_ready  in   1      sink accepts ascii
//  done         out  1      1-cycle pulse: stream fully drained
//  err          out  1      sticky: illegal symbol seen in current stream
//  char_cnt     out  CNT_W  characters handed off in current stream
//  bits_left    out  3      trailing bits discarded at end of last stream (0..6)
// BEHAVIOUR
//  Reset (async, rst_n=0): acc=0, nbits=0, state=RUN. All outputs 0
//   (ascii, ascii_valid, done, err, char_cnt, bits_left). sym_ready follows state.
//  Decode: 0x41-0x5A->0-25; 0x61-0x7A->26-51; 0x30-0x39->52-61; 0x2B->62; 0x2F->63.
//   0x3D '=' is padding: consumed, adds no bits, no error. Any other code is
//   consumed, adds no bits, and sets err.
//  Bit buffer: acc[11:0] and nbits (0..12). On accepting a legal symbol:
//   acc <= {acc,val} (low 12 bits kept), nbits <= nbits+6. MSB-first throughout.
//  sym_ready = (state==RUN) && (nbits<7). Symbol transfer = sym_valid & sym_ready.
//  Extract: when nbits>=7 and the output slot is free (!ascii_valid | ascii_ready):
//   ascii <= acc[nbits-1 -: 7]; nbits <= nbits-7; ascii_valid <= 1.
//   Otherwise ascii_valid clears on handshake; ascii stays stable while valid & !ready.
//  Accept and extract are mutually exclusive (nbits<7 vs nbits>=7).
//  Latency: from empty, 2nd symbol accepted at edge k -> ascii_valid at edge k+1.
//  char_cnt increments on each ascii handshake; wraps modulo 2^CNT_W.
//  FSM:
//   RUN   : accept symbols; a transfer with sym_last=1 -> DRAIN.
//   DRAIN : sym_ready=0; keep extracting; when nbits<7 and ascii_valid=0 -> DONE.
//   DONE  : done=1 for exactly one cycle; bits_left<=nbits; acc,nbits<=0 -> RUN.
//  Stream boundary: err and char_cnt hold after done and clear at the first symbol
//   transfer of the next stream (that symbol's own err/count effect applies).
//  Invalid symbol carrying sym_last: still ends the stream (-> DRAIN).
//  sym_last on a stream of one symbol: no chars, done, bits_left=6.
//  Reset mid-stream: everything clears immediately; a pending char is lost; no done.
// TESTING
//  1 "gwocQ", last on 'Q' -> ascii 0x41,0x42,0x43,0x44; char_cnt=4; bits_left=2; done x1.
//  2 "QUJDREVG" 1st 7 syms ("QUJDREV"), last on 'V' -> 42 bits -> 6 chars; bits_left=0.
//  3 "g*wocQ" with '=' after 'Q' (last on '=') -> err=1, output still "ABCD";
//     same stream without '*' -> err=0.
//  4 case 1 with ascii_ready=0 for 10 cycles after 1st valid -> ascii held at 0x41,
//     sym_ready=0 while nbits>=7, no char lost or duplicated; total 4 chars.
//  5 assert rst_n=0 after 3 symbols of case 1 -> outputs 0 asynchronously; rerun
//     case 1 -> identical result to scenario 1.
//  6 single 'A' with sym_last -> no ascii_valid; done pulse; bits_left=6; char_cnt=0.

Source files
------------

// File: rtl/base642a_rx.sv
// Base64-to-ASCII decoder: unpacks 6-bit base64 values MSB-first into 7-bit
// characters, with valid/ready handshakes on both sides and per-stream status.
module base642a_rx #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       sym_in,
  input  logic             sym_valid,
  output logic             sym_ready,
  input  logic             sym_last,
  output logic [6:0]       ascii,
  output logic             ascii_valid,
  input  logic             ascii_ready,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] char_cnt,
  output logic [2:0]       bits_left
);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DRAIN = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [11:0]      r_acc;
  logic [3:0]       r_nbits;
  logic             r_new_stream;
  logic [6:0]       r_ascii;
  logic             r_ascii_valid;
  logic             r_err;
  logic [CNT_W-1:0] r_char_cnt;
  logic [2:0]       r_bits_left;

  logic             w_sym_ready;
  logic             w_done;
  logic             w_xfer;
  logic             w_extract;
  logic             w_hshk;
  logic [7:0]       w_dec;
  logic             w_legal;
  logic             w_illegal;
  logic [3:0]       w_shift;
  logic [11:0]      w_acc_sh;
  logic [CNT_W-1:0] w_cnt_base;

  // Returns {is_pad, is_legal, value[5:0]} for one base64 character code.
  function automatic logic [7:0] decode_sym(input logic [6:0] code);
    logic [6:0] d;
    logic [7:0] res;
    d   = 7'd0;
    res = 8'd0;
    if ((code >= 7'h41) && (code <= 7'h5A)) begin
      d   = code - 7'h41;
      res = {1'b0, 1'b1, d[5:0]};
    end else if ((code >= 7'h61) && (code <= 7'h7A)) begin
      d   = code - 7'h47;
      res = {1'b0, 1'b1, d[5:0]};
    end else if ((code >= 7'h30) && (code <= 7'h39)) begin
      d   = code + 7'h04;
      res = {1'b0, 1'b1, d[5:0]};
    end else if (code == 7'h2B) begin
      res = {1'b0, 1'b1, 6'd62};
    end else if (code == 7'h2F) begin
      res = {1'b0, 1'b1, 6'd63};
    end else if (code == 7'h3D) begin
      res = {1'b1, 1'b0, 6'd0};
    end else begin
      res = 8'd0;
    end
    return res;
  endfunction

  always_comb begin
    w_dec     = decode_sym(sym_in);
    w_legal   = w_dec[6];
    w_illegal = ~w_dec[7] & ~w_dec[6];
    w_xfer    = sym_valid & w_sym_ready;
    w_hshk    = r_ascii_valid & ascii_ready;
    w_extract = (r_nbits >= 4'd7) && (!r_ascii_valid || ascii_ready);
    w_shift   = r_nbits - 4'd7;
    w_acc_sh  = r_acc >> w_shift;
    if (w_xfer && r_new_stream) begin
      w_cnt_base = {CNT_W{1'b0}};
    end else begin
      w_cnt_base = r_char_cnt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_RUN: begin
        if (w_xfer && sym_last) begin
          w_state_nxt = S_DRAIN;
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      S_DRAIN: begin
        if ((r_nbits < 4'd7) && !r_ascii_valid) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DONE:  w_state_nxt = S_RUN;
      default: w_state_nxt = S_RUN;
    endcase
  end

  always_comb begin
    w_sym_ready = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_RUN: begin
        w_sym_ready = (r_nbits < 4'd7);
        w_done      = 1'b0;
      end
      S_DRAIN: begin
        w_sym_ready = 1'b0;
        w_done      = 1'b0;
      end
      S_DONE: begin
        w_sym_ready = 1'b0;
        w_done      = 1'b1;
      end
      default: begin
        w_sym_ready = 1'b0;
        w_done      = 1'b0;
      end
    endcase
  end

  // Bit buffer: symbols append 6 bits at the LSB end, characters leave from the MSB end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc        <= 12'd0;
      r_nbits      <= 4'd0;
      r_new_stream <= 1'b1;
    end else if (r_state == S_DONE) begin
      r_acc        <= 12'd0;
      r_nbits      <= 4'd0;
      r_new_stream <= 1'b1;
    end else if (w_xfer) begin
      r_new_stream <= 1'b0;
      if (w_legal) begin
        r_acc   <= {r_acc[5:0], w_dec[5:0]};
        r_nbits <= r_nbits + 4'd6;
      end
    end else if (w_extract) begin
      r_nbits <= r_nbits - 4'd7;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ascii       <= 7'd0;
      r_ascii_valid <= 1'b0;
    end else if (w_extract) begin
      r_ascii       <= w_acc_sh[6:0];
      r_ascii_valid <= 1'b1;
    end else if (w_hshk) begin
      r_ascii_valid <= 1'b0;
    end
  end

  // Status holds across the stream boundary and restarts on the next stream's first symbol.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err       <= 1'b0;
      r_char_cnt  <= {CNT_W{1'b0}};
      r_bits_left <= 3'd0;
    end else begin
      if (w_xfer) begin
        r_err <= (r_new_stream ? 1'b0 : r_err) | w_illegal;
      end
      if (w_hshk) begin
        r_char_cnt <= w_cnt_base + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        r_char_cnt <= w_cnt_base;
      end
      if ((r_state == S_DRAIN) && (w_state_nxt == S_DONE)) begin
        r_bits_left <= r_nbits[2:0];
      end
    end
  end

  assign sym_ready   = w_sym_ready;
  assign done        = w_done;
  assign ascii       = r_ascii;
  assign ascii_valid = r_ascii_valid;
  assign err         = r_err;
  assign char_cnt    = r_char_cnt;
  assign bits_left   = r_bits_left;

endmodule
